// File: rtl/game_state_ctrl.sv
// game_state_ctrl: two-player hand-game round FSM with scoring; define TURN_TIMEOUT_EN to enable per-turn timeout and forfeit
module game_state_ctrl #(
  parameter int TURN_CYCLES  = 200,
  parameter int WIN_SCORE    = 3,
  parameter int JUDGE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       p1_btn,
  input  logic       p2_btn,
  input  logic [3:0] p1_val,
  input  logic [3:0] p2_val,
  output logic [2:0] state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic [7:0] timer
);
  localparam logic [2:0] IDLE        = 3'b000;
  localparam logic [2:0] ROUND_START = 3'b001;
  localparam logic [2:0] P1_TURN     = 3'b010;
  localparam logic [2:0] P1_HANDED   = 3'b011;
  localparam logic [2:0] P2_TURN     = 3'b101;
  localparam logic [2:0] P2_HANDED   = 3'b100;
  localparam logic [2:0] JUDGE       = 3'b110;
  localparam logic [2:0] GAME_OVER   = 3'b111;
  localparam logic [3:0] WIN         = 4'(WIN_SCORE);
  localparam logic [3:0] JLAST       = 4'(JUDGE_CYCLES - 1);
  localparam logic [7:0] TLOAD       = 8'(TURN_CYCLES - 1);
`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       start_q, p1_q, p2_q;
  logic       start_ev, p1_ev, p2_ev;
  logic [3:0] p1_lat, p2_lat, jcnt;
  logic       p1_ff, p2_ff;
  logic       timeout;
  logic [2:0] state_nxt;
  logic [3:0] p1_score_nxt, p2_score_nxt, p1_lat_nxt, p2_lat_nxt, jcnt_nxt;
  logic [1:0] winner_nxt;
  logic       p1_ff_nxt, p2_ff_nxt;
  logic [7:0] timer_nxt;
  logic       new_game, enter_judge, p1_pt, p2_pt;

  assign start_ev = start & ~start_q;
  assign p1_ev    = p1_btn & ~p1_q;
  assign p2_ev    = p2_btn & ~p2_q;
  assign timeout  = TO_EN && timer == 8'd0;

  // State register and previous-value flops for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= start;
      p1_q    <= p1_btn;
      p2_q    <= p2_btn;
    end
  end

  // Next-state decision; a press in the same cycle as timeout takes priority
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        state_nxt = start_ev ? ROUND_START : IDLE;
      ROUND_START: state_nxt = P1_TURN;
      P1_TURN:     state_nxt = p1_ev ? P1_HANDED : timeout ? JUDGE : P1_TURN;
      P1_HANDED:   state_nxt = P2_TURN;
      P2_TURN:     state_nxt = p2_ev ? P2_HANDED : timeout ? JUDGE : P2_TURN;
      P2_HANDED:   state_nxt = JUDGE;
      JUDGE:       state_nxt = (jcnt != JLAST) ? JUDGE :
                               (p1_score == WIN || p2_score == WIN) ? GAME_OVER : ROUND_START;
      GAME_OVER:   state_nxt = start_ev ? ROUND_START : GAME_OVER;
      default:     state_nxt = IDLE;
    endcase
  end

  // Next values of scores, winner, latches, forfeit flags, judge counter and timer; scoring lands as JUDGE is entered
  always_comb begin
    new_game     = start_ev && (state == IDLE || state == GAME_OVER);
    enter_judge  = state_nxt == JUDGE && state != JUDGE;
    p1_lat_nxt   = (state == ROUND_START) ? 4'd0 : (state == P1_TURN && p1_ev) ? p1_val : p1_lat;
    p2_lat_nxt   = (state == ROUND_START) ? 4'd0 : (state == P2_TURN && p2_ev) ? p2_val : p2_lat;
    p1_ff_nxt    = (state == ROUND_START) ? 1'b0 : (state == P1_TURN && state_nxt == JUDGE) ? 1'b1 : p1_ff;
    p2_ff_nxt    = (state == ROUND_START) ? 1'b0 : (state == P2_TURN && state_nxt == JUDGE) ? 1'b1 : p2_ff;
    p1_pt        = enter_judge && (p2_ff_nxt || (!p1_ff_nxt && p1_lat_nxt > p2_lat_nxt));
    p2_pt        = enter_judge && (p1_ff_nxt || (!p2_ff_nxt && p2_lat_nxt > p1_lat_nxt));
    p1_score_nxt = new_game ? 4'd0 : (p1_pt && p1_score != WIN) ? p1_score + 4'd1 : p1_score;
    p2_score_nxt = new_game ? 4'd0 : (p2_pt && p2_score != WIN) ? p2_score + 4'd1 : p2_score;
    winner_nxt   = new_game ? 2'b00 :
                   (state_nxt == GAME_OVER && state != GAME_OVER) ?
                   ((p1_score == WIN) ? 2'b01 : (p2_score == WIN) ? 2'b10 : 2'b00) : winner;
    jcnt_nxt     = (state == JUDGE) ? jcnt + 4'd1 : 4'd0;
    timer_nxt    = !TO_EN ? 8'd0 :
                   ((state_nxt == P1_TURN || state_nxt == P2_TURN) && state_nxt != state) ? TLOAD :
                   ((state == P1_TURN || state == P2_TURN) && state_nxt == state) ? timer - 8'd1 : 8'd0;
  end

  // Registered datapath: scores, winner, hand latches, forfeit flags, judge counter, turn timer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_score <= 4'd0;
      p2_score <= 4'd0;
      winner   <= 2'b00;
      p1_lat   <= 4'd0;
      p2_lat   <= 4'd0;
      p1_ff    <= 1'b0;
      p2_ff    <= 1'b0;
      jcnt     <= 4'd0;
      timer    <= 8'd0;
    end else begin
      p1_score <= p1_score_nxt;
      p2_score <= p2_score_nxt;
      winner   <= winner_nxt;
      p1_lat   <= p1_lat_nxt;
      p2_lat   <= p2_lat_nxt;
      p1_ff    <= p1_ff_nxt;
      p2_ff    <= p2_ff_nxt;
      jcnt     <= jcnt_nxt;
      timer    <= timer_nxt;
    end
  end
endmodule
